// File: rtl/scan_move_sequencer.sv
// scan_move_sequencer
//
// Steps a fixed token program of quarter-turn moves and observation points
// for a 48-sticker cube scan (24 corner observations, then 24 edge
// observations). On each obs_req it runs the moves up to the next
// observation token, waits for each move to complete, lets the sensor settle
// for SETTLE_CYCLES and pulses sensor_stable. After the last observation it
// plays out the remaining tokens unprompted so the cube returns to its
// original orientation, then parks in DONE.
//
// Ports
//   clock, reset   system clock; synchronous active-high reset
//   start          pulse; begins a scan from IDLE or DONE
//   obs_req        pulse; request the next observation position
//   move_ready     motor driver accepts move_code while move_valid is high
//   motor_done     pulse; the accepted move has physically completed
//   move_valid     a move is being offered
//   move_code      [2:0] face (U,L,F,R,B,D = 0..5), [3] counter-clockwise
//   sensor_stable  pulse; cube positioned and settled for observation
//   obs_index      current / last observation index, 0..47
//   corner_sel     1 while obs_index < 24 (corner sensor)
//   busy           high outside IDLE and DONE
//   scan_done      high in DONE
module scan_move_sequencer #(
  parameter logic [15:0] SETTLE_CYCLES = 16'd50000,
  parameter int          PROG_LEN      = 184
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       obs_req,
  input  logic       move_ready,
  input  logic       motor_done,
  output logic       move_valid,
  output logic [3:0] move_code,
  output logic       sensor_stable,
  output logic [5:0] obs_index,
  output logic       corner_sel,
  output logic       busy,
  output logic       scan_done
);

  localparam logic [3:0] TOK_OBS = 4'd6;
  localparam logic [3:0] TOK_END = 4'd7;
  localparam int         PROG_BITS = 740;

  // Token 0 sits in the most significant nibble. "{}" = OBS U OBS U OBS U OBS U.
  localparam logic [PROG_BITS-1:0] PROGRAM = {
    // corners
    32'h6060_6060,
    8'h2C, 32'h6060_6060, 8'h4A,
    8'h93, 32'h6060_6060, 8'hB1,
    8'hA4, 32'h6060_6060, 8'hC2,
    8'h1B, 32'h6060_6060, 8'h39,
    16'h1133, 32'h6060_6060, 16'h1133,
    // edges
    32'h6060_6060,
    24'h2C_102C, 32'h6060_6060, 24'h4A_894A,
    24'h93_2893, 32'h6060_6060, 24'hB1_0AB1,
    24'hA4_30A4, 32'h6060_6060, 24'hC2_8BC2,
    24'h1B_C01B, 32'h6060_6060, 24'h39_8439,
    32'h3311_2244, 32'h6060_6060, 32'h4422_1133,
    // end marker
    4'h7
  };

  typedef enum logic [2:0] {
    IDLE, WAIT_REQ, FETCH, ISSUE, WAIT_MOTOR, SETTLE, FLUSH, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [5:0]  obs_q, obs_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  tok_q, tok_d;
  logic [3:0]  rom [0:255];

  // Everything past the program reads as END.
  for (genvar i = 0; i < 256; i++) begin : g_rom
    if (i <= PROG_LEN && 4 * i < PROG_BITS) begin : g_tok
      assign rom[i] = PROGRAM[PROG_BITS-1-4*i -: 4];
    end else begin : g_end
      assign rom[i] = TOK_END;
    end
  end

  // Low three bits 0..5 are faces; 6 (OBS) and 7/14/15 (END) are not moves.
  function automatic logic is_move(input logic [3:0] t);
    return t[2:0] < 3'd6;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      obs_q   <= '0;
      cnt_q   <= '0;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      obs_q   <= obs_d;
      cnt_q   <= cnt_d;
      tok_q   <= tok_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    obs_d         = obs_q;
    cnt_d         = cnt_q;
    tok_d         = tok_q;
    move_valid    = 1'b0;
    sensor_stable = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d    = '0;
          obs_d   = '0;
          state_d = WAIT_REQ;
        end
      end
      WAIT_REQ: begin
        if (obs_req) state_d = FETCH;
      end
      FETCH: begin
        tok_d = rom[pc_q];
        // pc stops at 255 so it can never wrap back into the program.
        if (pc_q == 8'hFF) begin
          state_d = DONE;
        end else if (is_move(rom[pc_q])) begin
          state_d = ISSUE;
        end else if (rom[pc_q] == TOK_OBS) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          state_d = DONE;
        end
      end
      ISSUE: begin
        move_valid = 1'b1;
        if (move_ready) state_d = WAIT_MOTOR;
      end
      WAIT_MOTOR: begin
        if (motor_done) begin
          pc_d    = pc_q + 8'd1;
          state_d = FETCH;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_CYCLES) begin
          sensor_stable = 1'b1;
          pc_d          = pc_q + 8'd1;
          // obs_index stays on the pulsed observation during the pulse.
          if (obs_q == 6'd47) begin
            state_d = FLUSH;
          end else begin
            obs_d   = obs_q + 6'd1;
            state_d = WAIT_REQ;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      FLUSH: begin
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign move_code  = move_valid ? tok_q : 4'h0;
  assign obs_index  = obs_q;
  assign corner_sel = (obs_q < 6'd24);
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign scan_done  = (state_q == DONE);

endmodule

// File: tb/tb_scan_move_sequencer.sv
module tb_scan_move_sequencer;
  localparam logic [15:0] SETTLE = 16'd3;

  logic       clock = 1'b0;
  logic       reset, start, obs_req, move_ready, motor_done;
  logic       move_valid, sensor_stable, corner_sel, busy, scan_done;
  logic [3:0] move_code;
  logic [5:0] obs_index;

  scan_move_sequencer #(.SETTLE_CYCLES(SETTLE), .PROG_LEN(184)) dut (
    .clock(clock), .reset(reset), .start(start), .obs_req(obs_req),
    .move_ready(move_ready), .motor_done(motor_done),
    .move_valid(move_valid), .move_code(move_code),
    .sensor_stable(sensor_stable), .obs_index(obs_index),
    .corner_sel(corner_sel), .busy(busy), .scan_done(scan_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_obs;
    logic [3:0] code;
    int         idx;
    int         exp_cyc;
  } ev_t;

  ev_t        expq[$];
  logic [3:0] prog[$];
  int checks = 0, failures = 0;
  int cyc = 0, n_xfer = 0, n_obs = 0;
  int motor_en = 1, rdy_dly = 0, done_dly = 5;
  int p = 0, k = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Program text written as in the cube-scan description.
  task automatic add_text(input string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      case (c)
        "{": repeat (4) begin prog.push_back(4'd6); prog.push_back(4'd0); end
        "U": prog.push_back(4'd0);
        "L": prog.push_back(4'd1);
        "F": prog.push_back(4'd2);
        "R": prog.push_back(4'd3);
        "B": prog.push_back(4'd4);
        "D": prog.push_back(4'd5);
        "'": prog[prog.size()-1] = prog[prog.size()-1] | 4'h8;
        default: ;
      endcase
    end
  endtask

  task automatic push_ev(input bit is_obs, input logic [3:0] code, input int idx, input int exp_cyc);
    ev_t e;
    e.is_obs  = is_obs;
    e.code    = code;
    e.idx     = idx;
    e.exp_cyc = exp_cyc;
    expq.push_back(e);
  endtask

  // Motor driver model: ready after rdy_dly cycles, done done_dly cycles after transfer.
  initial begin
    move_ready = 1'b0;
    motor_done = 1'b0;
    forever begin
      tick();
      if (motor_en != 0 && move_valid) begin
        repeat (rdy_dly) tick();
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        repeat (done_dly - 1) tick();
        motor_done = 1'b1;
        tick();
        motor_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clock) begin : mon
    ev_t e;
    if (!reset && move_valid && move_ready) begin
      n_xfer++;
      if (expq.size() == 0) begin
        check("unexpected_move", int'(move_code), 99);
      end else begin
        e = expq.pop_front();
        check("event_kind_move", e.is_obs ? 1 : 0, 0);
        check("move_code", int'(move_code), int'(e.code));
      end
    end
    if (!reset && sensor_stable) begin
      n_obs++;
      if (expq.size() == 0) begin
        check("unexpected_obs", int'(obs_index), 99);
      end else begin
        e = expq.pop_front();
        check("event_kind_obs", e.is_obs ? 1 : 0, 1);
        check("obs_index", int'(obs_index), e.idx);
        check("corner_sel", int'(corner_sel), (e.idx < 24) ? 1 : 0);
        if (e.exp_cyc >= 0) check("obs_latency", cyc, e.exp_cyc);
      end
    end
  end

  task automatic request_obs();
    int nmoves;
    nmoves = 0;
    tick();
    while (p < prog.size() && prog[p] != 4'd6) begin
      push_ev(1'b0, prog[p], 0, -1);
      p++;
      nmoves++;
    end
    push_ev(1'b1, 4'd0, k, (nmoves == 0) ? cyc + int'(SETTLE) + 2 : -1);
    p++;
    k++;
    obs_req = 1'b1;
    tick();
    obs_req = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, expq.size(), 0);
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got t=%0t expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n, x0, o0;
    reset = 1'b1; start = 1'b0; obs_req = 1'b0;
    add_text("{} F B' {} B F' L' R {} R' L F' B {} B' F L R' {} R L' L L R R {} L L R R");
    add_text("{} F B' L U F B' {} B F' U' L' B F' L' R F U' L' R {} R' L U F' R' L ");
    add_text("F' B R U F' B {} B' F U' R' B' F L R' B' U L R' {} R L' U' B R L' ");
    add_text("R R L L F F B B {} B B F F L L R R");
    repeat (3) tick();
    check("rst_move_valid", int'(move_valid), 0);
    check("rst_move_code", int'(move_code), 0);
    check("rst_sensor_stable", int'(sensor_stable), 0);
    check("rst_obs_index", int'(obs_index), 0);
    check("rst_corner_sel", int'(corner_sel), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_scan_done", int'(scan_done), 0);
    reset = 1'b0;

    // First scan: immediate-ack motor for the first two observations.
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    request_obs();
    wait_drain("drain_obs0", 200);
    request_obs();
    wait_drain("drain_obs1", 200);

    // Back-pressure: 20-cycle stall with a stray obs_req in the middle.
    rdy_dly = 20; done_dly = 5;
    x0 = n_xfer;
    request_obs();
    n = 0;
    while (!move_valid && n < 50) begin tick(); n++; end
    check("stall_valid_seen", int'(move_valid), 1);
    for (int i = 0; i < 18; i++) begin
      tick();
      obs_req = (i == 5);
      @(negedge clock);
      check("stall_valid", int'(move_valid), 1);
      check("stall_code", int'(move_code), 0);
    end
    tick();
    obs_req = 1'b0;
    wait_drain("drain_stall", 300);
    check("stall_one_xfer", n_xfer - x0, 1);
    o0 = n_obs;
    repeat (20) tick();
    check("stray_req_ignored", n_obs - o0, 0);
    check("idle_no_move", int'(move_valid), 0);
    check("idle_busy", int'(busy), 1);

    // Rest of the scan with a slower motor.
    rdy_dly = 2; done_dly = 10;
    while (k < 48) begin
      request_obs();
      wait_drain("drain_obs", 500);
    end
    while (p < prog.size()) begin
      push_ev(1'b0, prog[p], 0, -1);
      p++;
    end
    n = 0;
    while (!scan_done && n < 1000) begin tick(); n++; end
    check("scan_done", int'(scan_done), 1);
    check("flush_drained", expq.size(), 0);
    check("total_obs", n_obs, 48);
    check("total_xfers", n_xfer, 136);
    check("done_busy", int'(busy), 0);
    check("done_obs_index", int'(obs_index), 47);

    // Start from DONE begins a new scan.
    pulse_start();
    check("restart_scan_done", int'(scan_done), 0);
    check("restart_busy", int'(busy), 1);
    check("restart_obs_index", int'(obs_index), 0);
    p = 0; k = 0;
    while (k < 30) begin
      request_obs();
      wait_drain("drain_obs2", 500);
    end

    // Reset while waiting on the motor during observation 30.
    x0 = n_xfer;
    request_obs();
    n = 0;
    while (n_xfer == x0 && n < 100) begin @(negedge clock); n++; end
    tick();
    check("wm_obs_index", int'(obs_index), 30);
    check("wm_move_valid", int'(move_valid), 0);
    check("wm_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    check("mid_rst_move_valid", int'(move_valid), 0);
    check("mid_rst_move_code", int'(move_code), 0);
    check("mid_rst_sensor_stable", int'(sensor_stable), 0);
    check("mid_rst_obs_index", int'(obs_index), 0);
    check("mid_rst_corner_sel", int'(corner_sel), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_scan_done", int'(scan_done), 0);
    expq.delete();
    reset = 1'b0;
    repeat (15) tick();

    // Fresh scan restarts at pc 0; a start while busy is ignored.
    pulse_start();
    p = 0; k = 0;
    request_obs();
    wait_drain("drain_after_reset", 200);
    pulse_start();
    check("busy_start_obs_index", int'(obs_index), 1);
    request_obs();
    wait_drain("drain_busy_start", 300);
    check("busy_start_still_busy", int'(busy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_move_sequencer.md
Name: scan_move_sequencer

Overview:
Sequences the motor moves and sensor settle timing for a full 48-sticker cube scan: 24 corner observations, then 24 edge observations. It holds a fixed token program of quarter-turn moves and observation points. It runs moves up to the next observation point, waits for the motors and the sensor to settle, then pulses sensor_stable to the state-determination FSM. It sits between that FSM (obs_req/sensor_stable) and the motor driver (move_valid/move_ready/motor_done).

Parameters:
SETTLE_CYCLES, 16'd50000, clock cycles to wait after the last motor_done before sensor_stable (0 = next cycle)
PROG_LEN, 184, number of tokens in the program ROM before END

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high
start  input  1  one-cycle pulse; begins a scan from IDLE or DONE
obs_req  input  1  one-cycle pulse from the determine FSM requesting the next observation position
move_ready  input  1  motor driver accepts move_code while move_valid is high
motor_done  input  1  one-cycle pulse; the accepted move has physically completed
move_valid  output  1  a move is being offered
move_code  output  4  [2:0] face (U=0,L=1,F=2,R=3,B=4,D=5), [3] 1 = counter-clockwise (prime)
sensor_stable  output  1  one-cycle pulse; cube is positioned and settled for observation
obs_index  output  6  index of the current or last observation, 0..47
corner_sel  output  1  1 when obs_index < 24 (read the corner sensor), else 0
busy  output  1  high in every state except IDLE and DONE
scan_done  output  1  high in DONE until start or reset

Behaviour:
- Token encoding (4 bits): 0..5 = clockwise face move; 8..13 = prime move; 6 = OBS; 7 = END; 14..15 illegal, treated as END.
- Program: "{}" expands to OBS U OBS U OBS U OBS U; X2 is encoded as two X tokens. Order:
  - Corners: {}; F B' {} B F'; L' R {} R' L; F' B {} B' F; L R' {} R L'; L L R R {} L L R R.
  - Edges: {}; F B' L U F B' {} B F' U' L' B F'; L' R F U' L' R {} R' L U F' R' L; F' B R U F' B {} B' F U' R' B' F; L R' B' U L R' {} R L' U' B R L'; R R L L F F B B {} B B F F L L R R; END.
  - Total is 184 tokens plus END, with exactly 48 OBS tokens. The ROM is 256 deep, indexed by an 8-bit pc.
- FSM states: IDLE, WAIT_REQ, FETCH, ISSUE, WAIT_MOTOR, SETTLE, FLUSH, DONE.
- Reset: state=IDLE, pc=0, obs_index=0, settle counter=0. All outputs are 0 except corner_sel, which is 1. Reset mid-move drops move_valid on the next edge; no undo moves are issued.
- IDLE/DONE + start: pc←0, obs_index←0, scan_done←0, go to WAIT_REQ. start is ignored in all other states.
- WAIT_REQ + obs_req: go to FETCH. obs_req is ignored in all other states (no queuing).
- FETCH: one cycle to read the token at pc.
  - Move token: ISSUE.
  - OBS token: SETTLE, counter←0.
  - END: DONE.
- ISSUE: move_valid=1 and move_code=token, held stable until a cycle with move_ready=1. That cycle is the transfer; next state is WAIT_MOTOR.
- WAIT_MOTOR: move_valid=0. On motor_done: pc←pc+1, go to FETCH. A motor_done arriving in the same cycle as the transfer is not counted.
- SETTLE: the counter increments each cycle. When the counter equals SETTLE_CYCLES:
  - pulse sensor_stable for exactly that one cycle and set pc←pc+1;
  - if obs_index==47, go to FLUSH; otherwise obs_index←obs_index+1 in the same edge and go to WAIT_REQ.
  - obs_index and corner_sel always refer to the observation being pulsed during the sensor_stable cycle.
- Latency: obs_req on an OBS token gives sensor_stable exactly SETTLE_CYCLES+2 cycles later.
- FLUSH: executes the remaining tokens autonomously through FETCH/ISSUE/WAIT_MOTOR with no obs_req needed. END leads to DONE. The cube ends in its original orientation.
- DONE: scan_done=1, busy=0, obs_index holds 47.
- pc never wraps; reaching pc=255 without END forces DONE.

Test Plan:
- Reset then start, obs_req; motor acks move_ready immediately: first token is OBS, so there is no move_valid, sensor_stable comes at SETTLE_CYCLES+2 with obs_index=0, corner_sel=1.
- Second obs_req: exactly one move_valid with move_code=4'h0 (U); motor_done 5 cycles later; then sensor_stable with obs_index=1.
- Full scan with a motor model (ready after 2 cycles, done after 10) and SETTLE_CYCLES=3:
  - exactly 48 sensor_stable pulses;
  - exactly 136 transfers (184 tokens − 48 OBS), with move_code stream matching the program;
  - corner_sel falls at obs_index=24;
  - scan_done rises after the final B,B,F,F,L,L,R,R flush.
- Back-pressure: hold move_ready=0 for 20 cycles → move_valid and move_code stay constant; exactly one transfer occurs; an extra obs_req during the stall is ignored.
- Assert reset while in WAIT_MOTOR at obs_index=30 → next cycle all outputs are at reset values; a new start restarts at pc=0 with obs_index=0.
- start pulsed while busy → no effect; start in DONE → scan_done clears and a new scan begins.
